// File: rtl/pipe_stage_elastic.sv
// Elastic two-entry (main + skid) pipeline stage carrying an instruction word and PC.
// Optional backpressure cycle counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_elastic #(
   parameter int unsigned        INSTR_W   = 32,
   parameter int unsigned        PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013)
`ifdef PIPE_STAGE_STALL_CNT_EN
   ,
   parameter int unsigned        CNT_W     = 16
`endif
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr_if,
   input  logic [PC_W-1:0]    pc_if,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] instr_id,
   output logic [PC_W-1:0]    pc_id
`ifdef PIPE_STAGE_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b11
   } state_t;

   logic               main_valid;
   logic [INSTR_W-1:0] main_instr;
   logic [PC_W-1:0]    main_pc;
   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;

   state_t state;
   logic   in_fire;
   logic   out_fire;

   // State is fully described by the two valid bits; skid never holds data without main.
   always_comb begin
      state = EMPTY;
      case ({skid_valid, main_valid})
         2'b01:   state = FULL;
         2'b11:   state = SKID;
         default: state = EMPTY;
      endcase
   end

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign instr_id  = main_valid ? main_instr : NOP_INSTR;
   assign pc_id     = main_pc;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid & out_ready;

   // Main/skid storage: reset beats flush beats handshake.
   always_ff @(posedge clock) begin
      if (!reset) begin
         main_valid <= 1'b0;
         main_instr <= '0;
         main_pc    <= '0;
         skid_valid <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         main_pc    <= '0;
         skid_valid <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_valid <= 1'b1;
                  main_instr <= instr_if;
                  main_pc    <= pc_if;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_instr <= instr_if;
                  main_pc    <= pc_if;
               end else if (in_fire) begin
                  skid_valid <= 1'b1;
                  skid_instr <= instr_if;
                  skid_pc    <= pc_if;
               end else if (out_fire) begin
                  main_valid <= 1'b0;
                  main_pc    <= '0;
               end
            end
            SKID: begin
               // in_ready is low here, so the only move is skid draining into main.
               if (out_fire) begin
                  main_instr <= skid_instr;
                  main_pc    <= skid_pc;
                  skid_valid <= 1'b0;
               end
            end
            default: begin
               main_valid <= main_valid;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_STALL_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating count of cycles a valid entry waits on downstream; only reset clears it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: a two-deep reference FIFO predicts every output.
// Stall counter checks are active when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_elastic;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic              clock;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [INSTR_W-1:0] instr_if;
   logic [PC_W-1:0]    pc_if;
   logic              out_valid;
   logic              out_ready;
   logic [INSTR_W-1:0] instr_id;
   logic [PC_W-1:0]    pc_id;

`ifdef PIPE_STAGE_STALL_CNT_EN
   localparam int unsigned CNT_W = 3;
   logic [CNT_W-1:0] stall_cnt;
   int               exp_cnt = 0;
`endif

   pipe_stage_elastic #(
      .INSTR_W   (INSTR_W),
      .PC_W      (PC_W),
      .NOP_INSTR (NOP)
`ifdef PIPE_STAGE_STALL_CNT_EN
      ,
      .CNT_W     (CNT_W)
`endif
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr_if  (instr_if),
      .pc_if     (pc_if),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr_id  (instr_id),
      .pc_id     (pc_id)
`ifdef PIPE_STAGE_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t sb[$];
   int     n_cmp  = 0;
   int     n_err  = 0;
   bit     chk_en = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare DUT against the reference FIFO, then advance the FIFO for the coming edge.
   always @(negedge clock) begin
      if (chk_en) begin
         bit     inf;
         bit     outf;
         entry_t e;
         check_eq("out_valid", 64'(out_valid), 64'(sb.size() != 0));
         check_eq("in_ready", 64'(in_ready), 64'(sb.size() < 2));
         if (sb.size() == 0) begin
            check_eq("instr_nop", 64'(instr_id), 64'(NOP));
            check_eq("pc_zero", 64'(pc_id), 64'(0));
         end else begin
            check_eq("instr_id", 64'(instr_id), 64'(sb[0].instr));
            check_eq("pc_id", 64'(pc_id), 64'(sb[0].pc));
         end
`ifdef PIPE_STAGE_STALL_CNT_EN
         check_eq("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
`endif
         inf  = in_valid && (sb.size() < 2);
         outf = (sb.size() != 0) && out_ready;
         if (!reset) begin
            sb.delete();
`ifdef PIPE_STAGE_STALL_CNT_EN
            exp_cnt = 0;
`endif
         end else begin
`ifdef PIPE_STAGE_STALL_CNT_EN
            if ((sb.size() != 0) && !out_ready && exp_cnt < 7) exp_cnt++;
`endif
            if (outf) void'(sb.pop_front());
            if (flush) begin
               sb.delete();
            end else if (inf) begin
               e.instr = instr_if;
               e.pc    = pc_if;
               sb.push_back(e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] i, input logic [31:0] p);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      instr_if = i;
      pc_if    = p;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      check_eq("push_timeout", 64'(in_ready), 64'(1));
      tick();
   endtask

   task automatic drain();
      int guard;
      guard     = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb.size() != 0 && guard < 50) begin
         tick();
         guard++;
      end
      check_eq("drain_timeout", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      instr_if  = 32'hDEAD_0001;
      pc_if     = 32'h0000_0FF0;
      out_ready = 1'b1;

      // Reset held two cycles with upstream offering data
      tick();
      chk_en = 1'b1;
      tick();
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_instr", 64'(instr_id), 64'(32'h0000_0013));
      check_eq("rst_in_ready", 64'(in_ready), 64'(1));
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      check_eq("rst_nothing_captured", 64'(out_valid), 64'(0));
      tick();

      // Streaming with out_ready held high
      push(32'hA0, 32'h100);
      check_eq("stream_lat", 64'(instr_id), 64'(32'hA0));
      push(32'hA1, 32'h104);
      push(32'hA2, 32'h108);
      in_valid = 1'b0;
      check_eq("stream_last", 64'(pc_id), 64'(32'h108));
      tick();
      tick();

      // Backpressure fills the skid; third entry waits upstream
      out_ready = 1'b0;
      push(32'h11, 32'h200);
      push(32'h22, 32'h204);
      in_valid = 1'b1;
      instr_if = 32'h33;
      pc_if    = 32'h208;
      check_eq("bp_in_ready", 64'(in_ready), 64'(0));
      check_eq("bp_hold", 64'(instr_id), 64'(32'h11));
      tick();
      tick();
      check_eq("bp_stable", 64'(instr_id), 64'(32'h11));
      out_ready = 1'b1;
      push(32'h33, 32'h208);
      drain();
      tick();

      // Flush while in SKID with a concurrent offer
      out_ready = 1'b0;
      push(32'h11, 32'h300);
      push(32'h22, 32'h304);
      in_valid = 1'b1;
      instr_if = 32'h44;
      pc_if    = 32'h308;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check_eq("flush_out_valid", 64'(out_valid), 64'(0));
      check_eq("flush_instr", 64'(instr_id), 64'(32'h0000_0013));
      check_eq("flush_pc", 64'(pc_id), 64'(0));
      check_eq("flush_in_ready", 64'(in_ready), 64'(1));
      out_ready = 1'b1;
      tick();
      tick();
      tick();

      // Reset in the middle of SKID
      out_ready = 1'b0;
      push(32'h11, 32'h400);
      push(32'h22, 32'h404);
      in_valid = 1'b0;
      reset    = 1'b0;
      tick();
      reset = 1'b1;
      check_eq("midrst_in_ready", 64'(in_ready), 64'(1));
      check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
      out_ready = 1'b1;
      push(32'h55, 32'h500);
      in_valid = 1'b0;
      check_eq("midrst_push", 64'(instr_id), 64'(32'h55));
      tick();

`ifdef PIPE_STAGE_STALL_CNT_EN
      // Stall counter: count, saturate, survive flush, clear on reset
      reset = 1'b0;
      tick();
      reset     = 1'b1;
      out_ready = 1'b0;
      push(32'h66, 32'h600);
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      check_eq("stall_5", 64'(stall_cnt), 64'(5));
      for (int k = 0; k < 5; k++) tick();
      check_eq("stall_sat", 64'(stall_cnt), 64'(7));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("stall_flush", 64'(stall_cnt), 64'(7));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_eq("stall_rst", 64'(stall_cnt), 64'(0));
      out_ready = 1'b1;
      tick();
`endif

      // Random traffic with occasional flushes
      for (int c = 0; c < 500; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         instr_if  = $urandom;
         pc_if     = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         tick();
      end
      flush = 1'b0;
      drain();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
